// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and constants for the sequential multiply path.
// Holds the FSM state encoding, the default operand width and the
// MULT/MULTU funct codes the decoder uses to derive is_signed.
package mult_pkg;

    localparam int WIDTH_DEF = 32;

    // Decoder funct codes: MULT selects the signed flavour, MULTU unsigned.
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Request/result bundle between pipeline control (master) and the multiply
// sequencer (slave). Master drives start/is_signed/op_a/op_b; slave returns
// busy/done and the architectural hi/lo product halves.
interface mult_seq_ctrl_if
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, op_a, op_b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mult_seq_ctrl_step.sv
// mult_step: one radix-2 shift-add iteration on {acc, mplier}.
// Latency: combinational.
// Backpressure: none; the sequencer decides when the result is registered.
// Ports: acc/mplier/mcand in, acc_nxt/mplier_nxt out.
module mult_step
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mplier,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0]   mplier_nxt
);

    logic [WIDTH:0] sum;

    always_comb begin
        // Carry out of the upper-half add becomes the new MSB after the shift.
        sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_nxt    = {sum, acc[WIDTH-1:1]};
        mplier_nxt = {1'b0, mplier[WIDTH-1:1]};
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequential MULT/MULTU producing the full product into hi/lo.
// Latency: WIDTH+2 edges from start to done (variable, shorter, with MULT_EARLY_TERM_EN).
// Backpressure: start is only taken in IDLE; requests while busy are dropped.
// Ports: clk, rst_n (async active-low), bus (slave side of mult_seq_ctrl_if).
// Optional macro MULT_EARLY_TERM_EN: skip remaining iterations once mplier is 0.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_seq_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 done_q, busy_q;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     mplier_step;
    logic [2*WIDTH-1:0]   result;
    logic                 last_iter;
    logic                 skip_rest;

    // Magnitudes only for signed requests; -(2^(W-1)) maps onto itself,
    // which is the correct unsigned magnitude.
    assign a_mag     = (bus.is_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    assign b_mag     = (bus.is_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
    assign result    = neg_q ? -acc_q : acc_q;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULT_EARLY_TERM_EN
    // Remaining iterations would only shift, so collapse them into one shift.
    logic [CNT_W:0]       remain;
    assign remain    = (CNT_W + 1)'(WIDTH) - {1'b0, cnt_q};
    assign skip_rest = (mplier_q == '0);
`else
    assign skip_rest = 1'b0;
`endif

    mult_step #(.WIDTH(WIDTH)) u_step (
        .acc        (acc_q),
        .mplier     (mplier_q),
        .mcand      (mcand_q),
        .acc_nxt    (acc_step),
        .mplier_nxt (mplier_step)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_iter || skip_rest) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        neg_q    <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                RUN: begin
`ifdef MULT_EARLY_TERM_EN
                    if (skip_rest) begin
                        acc_q <= acc_q >> remain;
                    end else
`endif
                    begin
                        acc_q    <= acc_step;
                        mplier_q <= mplier_step;
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end
                FINISH: begin
                    {hi_q, lo_q} <= result;
                    done_q       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: directed corner products plus randomized traffic,
// checked every cycle against a transaction-level model (64-bit products and
// an edge countdown per accepted request).
module tb_mult_seq_ctrl;
    import mult_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;

    mult_seq_ctrl_if #(.WIDTH(W)) bus ();

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Number of RUN edges the request occupies.
    function automatic int run_edges(input logic [W-1:0] b, input logic s);
        logic [W-1:0] mag;
        int bl;
        mag = (s && b[W-1]) ? -b : b;
        bl = 0;
        for (int i = 0; i < W; i++) if (mag[i]) bl = i + 1;
`ifdef MULT_EARLY_TERM_EN
        return (bl + 1 < W) ? bl + 1 : W;
`else
        if (bl < 0) return 0;
        return W;
`endif
    endfunction

    logic        m_busy, m_done;
    logic [63:0] m_prod, m_res;
    int          m_left;
    int          m_ops;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_res  <= '0;
            m_left <= 0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_res  <= m_prod;
                m_ops  <= m_ops + 1;
            end else begin
                m_left <= m_left - 1;
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_busy <= 1'b1;
                m_left <= run_edges(bus.op_b, bus.is_signed) + 1;
                m_prod <= ref_prod(bus.op_a, bus.op_b, bus.is_signed);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", 64'(bus.busy), 64'(m_busy));
            chk("cyc_done", 64'(bus.done), 64'(m_done));
            chk("cyc_hi", 64'(bus.hi), 64'(m_res[63:32]));
            chk("cyc_lo", 64'(bus.lo), 64'(m_res[31:0]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a = a;
        bus.op_b = b;
        bus.is_signed = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges after the start edge until done is seen.
    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                n = k;
                return;
            end
        end
        failures++;
        $display("FAIL wait_done: timeout, got no done expected done within 100 edges");
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dones;
        int ops0;
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        m_ops = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Model pins
        chk("model_u_max", ref_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), 64'hFFFF_FFFE_0000_0001);
        chk("model_s_m3x7", ref_prod(32'hFFFF_FFFD, 32'd7, 1'b1), 64'hFFFF_FFFF_FFFF_FFEB);

        // MULTU max*max, fixed latency: done after edge N+33
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(n);
        chk("umax_lat", 64'(n), 64'd33);
        chk("umax_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        chk("umax_lo", 64'(bus.lo), 64'h0000_0001);
        chk("umax_busy_in_done", 64'(bus.busy), 64'd0);

        issue(32'hFFFF_FFFD, 32'd7, 1'b1);
        wait_done(n);
        chk("m3x7_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("m3x7_lo", 64'(bus.lo), 64'hFFFF_FFEB);

        issue(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done(n);
        chk("minmin_hi", 64'(bus.hi), 64'h4000_0000);
        chk("minmin_lo", 64'(bus.lo), 64'h0000_0000);

        issue(32'h8000_0000, 32'd1, 1'b1);
        wait_done(n);
        chk("minx1_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        chk("minx1_lo", 64'(bus.lo), 64'h8000_0000);

        // Start while busy is ignored
        issue(32'h0000_1234, 32'h0000_0010, 1'b0);
        repeat (9) @(posedge clk);
        issue(32'd5, 32'd5, 1'b0);
        wait_done(n);
        chk("ign_hi", 64'(bus.hi), 64'd0);
        chk("ign_lo", 64'(bus.lo), 64'h0001_2340);

        // Start in the done cycle is accepted; hi/lo hold until the next done
        bus.start = 1'b1;
        bus.op_a = 32'h100;
        bus.op_b = 32'h100;
        bus.is_signed = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_busy", 64'(bus.busy), 64'd1);
        chk("b2b_hold_lo", 64'(bus.lo), 64'h0001_2340);
        wait_done(n);
        chk("b2b_lat", 64'(n), 64'(run_edges(32'h100, 1'b0) + 1));
        chk("b2b_lo", 64'(bus.lo), 64'h0001_0000);

        // 9*5 in either build
        issue(32'd9, 32'd5, 1'b0);
        wait_done(n);
        chk("9x5_hi", 64'(bus.hi), 64'd0);
        chk("9x5_lo", 64'(bus.lo), 64'd45);
`ifdef MULT_EARLY_TERM_EN
        chk("9x5_early_lat", 64'(n), 64'd5);
        issue(32'd5, 32'd0, 1'b0);
        wait_done(n);
        chk("bz_lat", 64'(n), 64'd2);
        chk("bz_hi", 64'(bus.hi), 64'd0);
        chk("bz_lo", 64'(bus.lo), 64'd0);
`else
        chk("9x5_lat", 64'(n), 64'd33);
`endif

        // Reset mid-RUN: immediate clear, no done afterwards
        issue(32'd7, 32'd6, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 64'(bus.busy), 64'd0);
        chk("mrst_hi", 64'(bus.hi), 64'd0);
        chk("mrst_lo", 64'(bus.lo), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("mrst_no_done", 64'(dones), 64'd0);

        // Random traffic, including starts while busy
        ops0 = m_ops;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op_a = pick();
            bus.op_b = pick();
            bus.is_signed = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (m_ops - ops0 < 20) begin
            failures++;
            $display("FAIL rand_ops: got %0d expected at least 20 completed ops", m_ops - ops0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
